program_loader: RTL and testbench



---
 rtl/loader_pkg.sv | 28 ++
 rtl/loader_checksum.sv | 35 +++
 rtl/program_loader.sv | 211 +++++++++++++++++++++
 tb/tb_program_loader.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and defaults for the program memory loader.
// LOADER_CHECKSUM_EN adds the CHECK state for the trailing checksum byte.
package loader_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int         ADDR_W_DEF    = 11;
  localparam int         WORD_W_DEF    = 14;
  localparam int         BYTE_W        = 8;
  localparam int         ADDR_HI_W     = ADDR_W_DEF - BYTE_W;
  localparam int         DATA_HI_W     = WORD_W_DEF - BYTE_W;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR_LO,
    ST_ADDR_HI,
    ST_CNT_LO,
    ST_CNT_HI,
    ST_DATA_LO,
    ST_DATA_HI,
    ST_WRITE,
`ifdef LOADER_CHECKSUM_EN
    ST_CHECK,
`endif
    ST_DONE,
    ST_ERR
  } state_t;

endpackage

// File: rtl/loader_checksum.sv
// 8-bit running sum of frame bytes; zero_o reports whether the sum including
// the byte currently presented on data_i would be zero.
module loader_checksum
  import loader_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       add_i,
  input  logic [7:0] data_i,
  output logic       zero_o
);

  logic [7:0] sum_q, sum_d;
  logic [7:0] sum_with;

  assign sum_with = sum_q + data_i;
  assign zero_o   = (sum_with == 8'h00);

  always_comb begin
    sum_d = sum_q;
    if (clr_i)
      sum_d = 8'h00;
    else if (add_i)
      sum_d = sum_with;
  end

  always_ff @(posedge clk) begin
    if (rst)
      sum_q <= 8'h00;
    else
      sum_q <= sum_d;
  end

endmodule

// File: rtl/program_loader.sv
// Framed serial byte stream to program memory writer; holds the core while loading.
// Build option: LOADER_CHECKSUM_EN enables the trailing CHK byte and its verification.
module program_loader
  import loader_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int         ADDR_W    = ADDR_W_DEF,
  parameter int         WORD_W    = WORD_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        Rx_data_in,
  input  logic              Rx_valid_in,
  output logic              Rx_ready_out,
  output logic [ADDR_W-1:0] Wr_addr_out,
  output logic [WORD_W-1:0] Wr_data_out,
  output logic              Wr_en_out,
  output logic              Cpu_hold_out,
  output logic [ADDR_W-1:0] Word_count_out,
  output logic              Load_done_out,
  output logic              Load_err_out
);

  localparam int                AHI_W = ADDR_W - BYTE_W;
  localparam int                DHI_W = WORD_W - BYTE_W;
  localparam logic [ADDR_W-1:0] ONE_A = 1;

  state_t            state_q, state_d;
  logic              rdy_q, rdy_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] wcnt_q, wcnt_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [7:0]        lo_q, lo_d;
  logic              wen_q, wen_d;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              xfer;
  logic              is_sync;
  logic [ADDR_W-1:0] wcnt_inc;
  logic [ADDR_W-1:0] cnt_full;
  state_t            end_state;

  assign xfer     = Rx_valid_in && rdy_q;
  assign is_sync  = (Rx_data_in == SYNC_BYTE);
  assign wcnt_inc = wcnt_q + ONE_A;
  assign cnt_full = {Rx_data_in[AHI_W-1:0], cnt_q[7:0]};

`ifdef LOADER_CHECKSUM_EN
  logic chk_clr, chk_add, chk_ok;

  assign end_state = ST_CHECK;
  assign chk_clr   = xfer && is_sync && (state_q == ST_IDLE || state_q == ST_DONE);
  assign chk_add   = xfer && (state_q inside {ST_ADDR_LO, ST_ADDR_HI, ST_CNT_LO, ST_CNT_HI,
                                              ST_DATA_LO, ST_DATA_HI, ST_CHECK});

  loader_checksum u_checksum (
    .clk    (clk),
    .rst    (reset),
    .clr_i  (chk_clr),
    .add_i  (chk_add),
    .data_i (Rx_data_in),
    .zero_o (chk_ok)
  );
`else
  assign end_state = ST_DONE;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    wcnt_d  = wcnt_q;
    wdata_d = wdata_q;
    lo_d    = lo_q;
    wen_d   = 1'b0;
    hold_d  = hold_q;
    done_d  = done_q;
    err_d   = err_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (xfer && is_sync) begin
          state_d = ST_ADDR_LO;
          hold_d  = 1'b1;
          done_d  = 1'b0;
          wcnt_d  = '0;
        end
      end
      ST_ADDR_LO: begin
        if (xfer) begin
          addr_d[7:0] = Rx_data_in;
          state_d     = ST_ADDR_HI;
        end
      end
      ST_ADDR_HI: begin
        if (xfer) begin
          if (|Rx_data_in[7:AHI_W]) begin
            state_d = ST_ERR;
          end else begin
            addr_d[ADDR_W-1:8] = Rx_data_in[AHI_W-1:0];
            state_d            = ST_CNT_LO;
          end
        end
      end
      ST_CNT_LO: begin
        if (xfer) begin
          cnt_d[7:0] = Rx_data_in;
          state_d    = ST_CNT_HI;
        end
      end
      ST_CNT_HI: begin
        if (xfer) begin
          if (|Rx_data_in[7:AHI_W]) begin
            state_d = ST_ERR;
          end else begin
            cnt_d = cnt_full;
            if (cnt_full == '0) state_d = end_state;
            else                state_d = ST_DATA_LO;
          end
        end
      end
      ST_DATA_LO: begin
        if (xfer) begin
          lo_d    = Rx_data_in;
          state_d = ST_DATA_HI;
        end
      end
      ST_DATA_HI: begin
        if (xfer) begin
          if (|Rx_data_in[7:DHI_W]) begin
            state_d = ST_ERR;
          end else begin
            wdata_d = {Rx_data_in[DHI_W-1:0], lo_q};
            wen_d   = 1'b1;
            state_d = ST_WRITE;
          end
        end
      end
      // Write strobe is live this cycle; address advances once it completes.
      ST_WRITE: begin
        addr_d = addr_q + ONE_A;
        wcnt_d = wcnt_inc;
        if (wcnt_inc == cnt_q) state_d = end_state;
        else                   state_d = ST_DATA_LO;
      end
`ifdef LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (xfer) begin
          if (chk_ok) state_d = ST_DONE;
          else        state_d = ST_ERR;
        end
      end
`endif
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (state_d == ST_DONE && state_q != ST_DONE) begin
      done_d = 1'b1;
      hold_d = 1'b0;
    end
    if (state_d == ST_ERR)
      err_d = 1'b1;

    rdy_d = !(state_d inside {ST_WRITE, ST_ERR});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      rdy_q   <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= '0;
      wcnt_q  <= '0;
      wdata_q <= '0;
      wen_q   <= 1'b0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      wcnt_q  <= wcnt_d;
      wdata_q <= wdata_d;
      wen_q   <= wen_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
    lo_q <= lo_d;
  end

  assign Rx_ready_out   = rdy_q;
  assign Wr_addr_out    = addr_q;
  assign Wr_data_out    = wdata_q;
  assign Wr_en_out      = wen_q;
  assign Cpu_hold_out   = hold_q;
  assign Word_count_out = wcnt_q;
  assign Load_done_out  = done_q;
  assign Load_err_out   = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed and randomized frame tests for program_loader against a frame-level model.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [10:0] wr_addr;
  logic [13:0] wr_data;
  logic        wr_en;
  logic        cpu_hold;
  logic [10:0] word_count;
  logic        load_done;
  logic        load_err;

  always #5 clk = ~clk;

  program_loader dut (
    .clk            (clk),
    .reset          (reset),
    .Rx_data_in     (rx_data),
    .Rx_valid_in    (rx_valid),
    .Rx_ready_out   (rx_ready),
    .Wr_addr_out    (wr_addr),
    .Wr_data_out    (wr_data),
    .Wr_en_out      (wr_en),
    .Cpu_hold_out   (cpu_hold),
    .Word_count_out (word_count),
    .Load_done_out  (load_done),
    .Load_err_out   (load_err)
  );

  typedef struct {
    logic [10:0] a;
    logic [13:0] d;
  } wr_t;

  int  checks   = 0;
  int  failures = 0;
  wr_t wlog[$];
  wr_t wexp[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every write strobe is logged; the loader must never accept a byte in that cycle.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      wlog.push_back('{a: wr_addr, d: wr_data});
      chk("bubble_on_write", {31'd0, rx_ready}, 32'd0);
    end
  end

  task automatic step(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    rx_valid = 1'b0;
    step($urandom_range(0, 2));
    rx_valid = 1'b1;
    rx_data  = b;
    n = 0;
    @(negedge clk);
    while (rx_ready !== 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (n >= 20) begin
      checks++;
      failures++;
      $error("FAIL ready_timeout observed=0 expected=1");
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_garbage(input int k);
    logic [7:0] g;
    for (int i = 0; i < k; i++) begin
      g = 8'($urandom_range(0, 255));
      if (g == 8'hA5) g = 8'h5A;
      send_byte(g);
    end
  endtask

  // Frame model: bytes from the field rules; expected writes at addr+k mod 2048.
  task automatic send_frame(input logic [10:0] addr, input int n, input logic [13:0] w[8],
                            input logic [7:0] chk_off);
    logic [7:0]  q[$];
    logic [7:0]  sum;
    logic [10:0] nn;
    nn = 11'(n);
    q.push_back(addr[7:0]);
    q.push_back({5'b0, addr[10:8]});
    q.push_back(nn[7:0]);
    q.push_back({5'b0, nn[10:8]});
    for (int k = 0; k < n; k++) begin
      q.push_back(w[k][7:0]);
      q.push_back({2'b00, w[k][13:8]});
      wexp.push_back('{a: 11'(addr + 11'(k)), d: w[k]});
    end
    sum = 8'h00;
    foreach (q[i]) sum = sum + q[i];
`ifdef LOADER_CHECKSUM_EN
    q.push_back(8'h00 - sum + chk_off);
`else
    if (chk_off != 8'h00) $display("note: checksum offset ignored without checksum build");
`endif
    send_byte(8'hA5);
    chk("hold_after_sync", {31'd0, cpu_hold}, 32'd1);
    chk("done_clr_on_sync", {31'd0, load_done}, 32'd0);
    chk("count_clr_on_sync", {21'd0, word_count}, 32'd0);
    foreach (q[i]) send_byte(q[i]);
`ifndef LOADER_CHECKSUM_EN
    if (n > 0) step(1);
`endif
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_nwrites"}, wlog.size(), wexp.size());
    for (int i = 0; i < wexp.size() && i < wlog.size(); i++) begin
      chk({tag, "_addr"}, {21'd0, wlog[i].a}, {21'd0, wexp[i].a});
      chk({tag, "_data"}, {18'd0, wlog[i].d}, {18'd0, wexp[i].d});
    end
    wlog.delete();
    wexp.delete();
  endtask

  task automatic check_done(input string tag, input int n);
    chk({tag, "_done"}, {31'd0, load_done}, 32'd1);
    chk({tag, "_hold"}, {31'd0, cpu_hold}, 32'd0);
    chk({tag, "_err"}, {31'd0, load_err}, 32'd0);
    chk({tag, "_count"}, {21'd0, word_count}, n);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_ready"}, {31'd0, rx_ready}, 32'd0);
    chk({tag, "_addr"}, {21'd0, wr_addr}, 32'd0);
    chk({tag, "_data"}, {18'd0, wr_data}, 32'd0);
    chk({tag, "_wen"}, {31'd0, wr_en}, 32'd0);
    chk({tag, "_hold"}, {31'd0, cpu_hold}, 32'd0);
    chk({tag, "_count"}, {21'd0, word_count}, 32'd0);
    chk({tag, "_done"}, {31'd0, load_done}, 32'd0);
    chk({tag, "_err"}, {31'd0, load_err}, 32'd0);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    rx_valid = 1'b0;
    step(1);
    check_reset_values("reset");
    reset = 1'b0;
    step(1);
    chk("ready_after_reset", {31'd0, rx_ready}, 32'd1);
  endtask

  initial begin
    logic [13:0] w[8];
    logic [10:0] a;
    int          n;

    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    step(3);
    do_reset();

    // Reference frame from the test plan, preceded by idle-state noise.
    send_garbage(3);
    chk("idle_garbage_count", {21'd0, word_count}, 32'd0);
    w[0] = 14'h0103;
    w[1] = 14'h05A5;
    send_frame(11'h010, 2, w, 8'h00);
    chk("plan_done_timing", {31'd0, load_done}, 32'd1);
    step(3);
    check_writes("plan");
    check_done("plan", 2);

    // Noise in DONE must leave the completed status alone.
    send_garbage(2);
    chk("done_garbage_done", {31'd0, load_done}, 32'd1);
    chk("done_garbage_count", {21'd0, word_count}, 32'd2);

    // Address wrap at the top of memory.
    w[0] = 14'($urandom);
    w[1] = 14'($urandom);
    send_frame(11'h7FF, 2, w, 8'h00);
    step(3);
    check_writes("wrap");
    check_done("wrap", 2);

    // Empty frame: completes with no write.
    send_frame(11'h000, 0, w, 8'h00);
    chk("n0_done_timing", {31'd0, load_done}, 32'd1);
    step(3);
    check_writes("n0");
    check_done("n0", 0);

    // Randomized frames.
    for (int f = 0; f < 4; f++) begin
      a = 11'($urandom);
      n = $urandom_range(1, 8);
      for (int k = 0; k < 8; k++) w[k] = 14'($urandom);
      send_garbage($urandom_range(0, 2));
      send_frame(a, n, w, 8'h00);
      chk("rand_done_timing", {31'd0, load_done}, 32'd1);
      step(3);
      check_writes("rand");
      check_done("rand", n);
    end

    // Reset after the first word of a frame, then a fresh frame.
    send_byte(8'hA5);
    send_byte(8'h40);
    send_byte(8'h00);
    send_byte(8'h03);
    send_byte(8'h00);
    send_byte(8'h22);
    send_byte(8'h11);
    step(2);
    wexp.push_back('{a: 11'h040, d: 14'h1122});
    check_writes("midreset_partial");
    reset = 1'b1;
    step(1);
    check_reset_values("midreset");
    reset = 1'b0;
    step(1);
    chk("midreset_ready", {31'd0, rx_ready}, 32'd1);
    a = 11'($urandom);
    for (int k = 0; k < 8; k++) w[k] = 14'($urandom);
    send_frame(a, 3, w, 8'h00);
    step(3);
    check_writes("after_reset");
    check_done("after_reset", 3);

    // Illegal DATA_HI on the second word: first word stays, no write for the bad one.
    send_byte(8'hA5);
    send_byte(8'h20);
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h34);
    send_byte(8'h12);
    send_byte(8'h77);
    send_byte(8'h40);
    chk("datahi_err", {31'd0, load_err}, 32'd1);
    chk("datahi_ready", {31'd0, rx_ready}, 32'd0);
    step(5);
    wexp.push_back('{a: 11'h020, d: 14'h1234});
    check_writes("datahi");
    chk("datahi_err_sticky", {31'd0, load_err}, 32'd1);
    chk("datahi_hold", {31'd0, cpu_hold}, 32'd1);
    chk("datahi_done", {31'd0, load_done}, 32'd0);
    do_reset();

    // Illegal ADDR_HI.
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h08);
    step(2);
    chk("addrhi_err", {31'd0, load_err}, 32'd1);
    chk("addrhi_ready", {31'd0, rx_ready}, 32'd0);
    check_writes("addrhi");
    do_reset();

`ifdef LOADER_CHECKSUM_EN
    // Checksum off by one: both words written, frame rejected.
    w[0] = 14'($urandom);
    w[1] = 14'($urandom);
    send_frame(11'h155, 2, w, 8'h01);
    step(3);
    check_writes("badchk");
    chk("badchk_err", {31'd0, load_err}, 32'd1);
    chk("badchk_done", {31'd0, load_done}, 32'd0);
    chk("badchk_hold", {31'd0, cpu_hold}, 32'd1);
    chk("badchk_ready", {31'd0, rx_ready}, 32'd0);
    do_reset();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
